// File: rtl/avg_mag_ctrl.sv
// avg_mag_ctrl: sequences the LFSR load, frames avg_mag accumulation windows with clr_acc
// and captures each window result into a valid/ready register. Optional overrun flag: AVG_CTRL_OVR_EN.
module avg_mag_ctrl #(
  parameter int N_SYM_LOG2 = 7,
  parameter int LOAD_CYC   = 4,
  parameter int CAP_DLY    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sam_clk_en,
  input  logic               sym_clk_en,
  input  logic               start,
  input  logic               stop,
  input  logic signed [17:0] ref_lvl_in,
  input  logic signed [17:0] map_out_pwr_in,
  output logic               load,
  output logic               clr_acc,
  output logic signed [17:0] ref_lvl,
  output logic signed [17:0] map_out_pwr,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               busy
`ifdef AVG_CTRL_OVR_EN
  ,
  output logic               overrun
`endif
);

  localparam int CW = ($clog2(LOAD_CYC + 1) > 3) ? $clog2(LOAD_CYC + 1) : 3;
  localparam logic [N_SYM_LOG2-1:0] SYM_TC    = '1;
  localparam logic [CW-1:0]         LOAD_LAST = CW'(LOAD_CYC);
  localparam logic [CW-1:0]         CAP_LAST  = CW'(CAP_DLY);

  typedef enum logic [2:0] {IDLE, LOAD_WAIT, LOAD, ACCUM, DUMP, CAPTURE} state_t;

  state_t                state;
  logic [N_SYM_LOG2-1:0] sym_cnt;
  logic [CW-1:0]         cnt;
  logic                  first;
  logic                  stop_pend;
  logic                  capture;

  // The first window after load is contaminated by the LFSR transient and is never reported.
  assign capture = (state == CAPTURE) && (cnt == CAP_LAST) && !first;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sym_cnt     <= '0;
      cnt         <= '0;
      first       <= 1'b0;
      stop_pend   <= 1'b0;
      load        <= 1'b0;
      clr_acc     <= 1'b0;
      busy        <= 1'b0;
      res_valid   <= 1'b0;
      ref_lvl     <= '0;
      map_out_pwr <= '0;
    end else begin
      if (res_ready)
        res_valid <= 1'b0;
      if (capture) begin
        res_valid   <= 1'b1;
        ref_lvl     <= ref_lvl_in;
        map_out_pwr <= map_out_pwr_in;
      end

      // Symbols keep counting through DUMP/CAPTURE so consecutive windows have no gap.
      if (state == ACCUM || state == DUMP || state == CAPTURE) begin
        if (stop)
          stop_pend <= 1'b1;
        if (sym_clk_en)
          sym_cnt <= sym_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD_WAIT;
            busy  <= 1'b1;
          end
        end
        LOAD_WAIT: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (sam_clk_en) begin
            state <= LOAD;
            load  <= 1'b1;
            cnt   <= CW'(1);
          end
        end
        LOAD: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
            load  <= 1'b0;
          end else if (cnt == LOAD_LAST) begin
            state   <= ACCUM;
            load    <= 1'b0;
            sym_cnt <= '0;
            first   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ACCUM: begin
          if (sym_clk_en && sym_cnt == SYM_TC) begin
            state   <= DUMP;
            clr_acc <= 1'b1;
          end
        end
        DUMP: begin
          state   <= CAPTURE;
          clr_acc <= 1'b0;
          cnt     <= CW'(1);
        end
        CAPTURE: begin
          if (cnt == CAP_LAST) begin
            first <= 1'b0;
            if (stop_pend || stop) begin
              state     <= IDLE;
              busy      <= 1'b0;
              stop_pend <= 1'b0;
            end else begin
              state <= ACCUM;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          load    <= 1'b0;
          clr_acc <= 1'b0;
        end
      endcase
    end
  end

`ifdef AVG_CTRL_OVR_EN
  // Sticky until a new run starts; a capture coinciding with the accept is not an overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      overrun <= 1'b0;
    else if (state == IDLE && start)
      overrun <= 1'b0;
    else if (capture && res_valid && !res_ready)
      overrun <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_avg_mag_ctrl.sv
// tb_avg_mag_ctrl: directed vector table for load/window/handshake sequencing plus
// hand-written sequences for periodic windows, backpressure, stop and async reset.
module tb_avg_mag_ctrl;

  logic               clk = 1'b0;
  logic               reset;
  logic               sam_clk_en = 1'b0;
  logic               sym_clk_en = 1'b0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic signed [17:0] ref_lvl_in = '0;
  logic signed [17:0] map_out_pwr_in = '0;
  logic               load;
  logic               clr_acc;
  logic signed [17:0] ref_lvl;
  logic signed [17:0] map_out_pwr;
  logic               res_valid;
  logic               res_ready = 1'b1;
  logic               busy;
`ifdef AVG_CTRL_OVR_EN
  logic               overrun;
`endif

  avg_mag_ctrl #(.N_SYM_LOG2(2), .LOAD_CYC(4), .CAP_DLY(1)) dut (
    .clk(clk),
    .reset(reset),
    .sam_clk_en(sam_clk_en),
    .sym_clk_en(sym_clk_en),
    .start(start),
    .stop(stop),
    .ref_lvl_in(ref_lvl_in),
    .map_out_pwr_in(map_out_pwr_in),
    .load(load),
    .clr_acc(clr_acc),
    .ref_lvl(ref_lvl),
    .map_out_pwr(map_out_pwr),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .busy(busy)
`ifdef AVG_CTRL_OVR_EN
    ,
    .overrun(overrun)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int start, stop, ready, sam, sym;
    int load, clr, valid, busy, ref_v, pwr_v;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs[NV];

  int n_chk = 0;
  int n_fail = 0;
  int ph = 0;
  int cyc = 0;
  bit per_on = 1'b0;
  bit last_sam, last_sym;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock: periodic strobes (sam every 4, sym every 16) and a ramping data input.
  task automatic tick();
    if (per_on) begin
      sam_clk_en     = (ph % 4 == 0);
      sym_clk_en     = (ph % 16 == 0);
      ref_lvl_in     = 18'(1000 + cyc);
      map_out_pwr_in = 18'(-500 - cyc);
    end
    @(posedge clk);
    #1;
    last_sam = sam_clk_en;
    last_sym = sym_clk_en;
    ph++;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    sam_clk_en = 1'b0;
    sym_clk_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic load_seq(input string tag);
    int n;
    bit pre;
    per_on = 1'b1;
    ph = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy"}, busy, 1);
    n = 0;
    pre = 1'b0;
    while (!load && n < 20) begin
      tick();
      n++;
      if (!load && last_sam) pre = 1'b1;
    end
    check({tag, "_load_on_sam"}, 64'(load && last_sam && !pre), 1);
    n = 0;
    while (load && n < 10) begin
      n++;
      tick();
    end
    check({tag, "_load_width"}, n, 4);
    $display("%s: load sequence done at cycle %0d", tag, cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nclr, nval, nsym, sym_at_clr0, nlow, cap_at, val_at, nb, n;
    int clr_cyc[4];
    int val_cyc[4];
    int exp_r, exp_p;
    bit saw_clr, saw_val, got_first;

    //            st sp rd sa sy  ld cl va bu  ref    pwr
    vecs[0]  = '{0, 1, 1, 1, 0,  0, 0, 0, 0,  0,    0};
    vecs[1]  = '{1, 0, 1, 1, 0,  0, 0, 0, 1,  0,    0};
    vecs[2]  = '{0, 0, 1, 0, 0,  0, 0, 0, 1,  0,    0};
    vecs[3]  = '{0, 0, 1, 1, 0,  1, 0, 0, 1,  0,    0};
    vecs[4]  = '{0, 0, 1, 0, 0,  1, 0, 0, 1,  0,    0};
    vecs[5]  = '{0, 0, 1, 0, 0,  1, 0, 0, 1,  0,    0};
    vecs[6]  = '{0, 0, 1, 0, 0,  1, 0, 0, 1,  0,    0};
    vecs[7]  = '{0, 0, 1, 0, 0,  0, 0, 0, 1,  0,    0};
    vecs[8]  = '{0, 0, 1, 1, 1,  0, 0, 0, 1,  0,    0};
    vecs[9]  = '{0, 0, 1, 1, 1,  0, 0, 0, 1,  0,    0};
    vecs[10] = '{0, 0, 1, 1, 1,  0, 0, 0, 1,  0,    0};
    vecs[11] = '{0, 0, 1, 1, 1,  0, 1, 0, 1,  0,    0};
    vecs[12] = '{0, 0, 1, 0, 0,  0, 0, 0, 1,  0,    0};
    vecs[13] = '{0, 0, 1, 0, 0,  0, 0, 0, 1,  0,    0};
    vecs[14] = '{0, 0, 1, 1, 1,  0, 0, 0, 1,  0,    0};
    vecs[15] = '{0, 0, 1, 1, 1,  0, 0, 0, 1,  0,    0};
    vecs[16] = '{0, 0, 1, 1, 1,  0, 0, 0, 1,  0,    0};
    vecs[17] = '{0, 0, 1, 1, 1,  0, 1, 0, 1,  0,    0};
    vecs[18] = '{0, 0, 1, 0, 0,  0, 0, 0, 1,  0,    0};
    vecs[19] = '{0, 0, 0, 0, 0,  0, 0, 1, 1,  1000, -500};
    vecs[20] = '{0, 0, 0, 0, 0,  0, 0, 1, 1,  1000, -500};
    vecs[21] = '{0, 0, 1, 0, 0,  0, 0, 0, 1,  1000, -500};

    // Reset and idle
    do_reset();
    check("rst_load", load, 0);
    check("rst_clr", clr_acc, 0);
    check("rst_valid", res_valid, 0);
    check("rst_ref", ref_lvl, 0);
    check("rst_pwr", map_out_pwr, 0);
    check("rst_busy", busy, 0);
`ifdef AVG_CTRL_OVR_EN
    check("rst_ovr", overrun, 0);
`endif
    per_on = 1'b1;
    nb = 0;
    repeat (100) begin
      tick();
      nb += int'(busy);
    end
    check("idle_busy_100", nb, 0);
    $display("idle: busy samples over 100 clocks = %0d", nb);

    // Vector table: cycle-by-cycle load, first (skipped) window, second window, handshake
    do_reset();
    per_on = 1'b0;
    ref_lvl_in = 18'sd1000;
    map_out_pwr_in = -18'sd500;
    for (int i = 0; i < NV; i++) begin
      start      = 1'(vecs[i].start);
      stop       = 1'(vecs[i].stop);
      res_ready  = 1'(vecs[i].ready);
      sam_clk_en = 1'(vecs[i].sam);
      sym_clk_en = 1'(vecs[i].sym);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_load", i), load, vecs[i].load);
      check($sformatf("v%0d_clr", i), clr_acc, vecs[i].clr);
      check($sformatf("v%0d_valid", i), res_valid, vecs[i].valid);
      check($sformatf("v%0d_busy", i), busy, vecs[i].busy);
      check($sformatf("v%0d_ref", i), ref_lvl, vecs[i].ref_v);
      check($sformatf("v%0d_pwr", i), map_out_pwr, vecs[i].pwr_v);
      $display("vec %0d: load=%0b clr=%0b valid=%0b busy=%0b ref=%0d pwr=%0d",
               i, load, clr_acc, res_valid, busy, ref_lvl, map_out_pwr);
    end

    // Periodic windows: clr every 64 clocks, results from the second window at clr+2
    do_reset();
    res_ready = 1'b1;
    load_seq("ld");
    nclr = 0; nval = 0; nsym = 0; sym_at_clr0 = -1;
    for (int i = 0; i < 4; i++) begin clr_cyc[i] = 0; val_cyc[i] = 0; end
    for (int i = 0; i < 300; i++) begin
      tick();
      if (last_sym) nsym++;
      if (clr_acc) begin
        if (nclr < 4) clr_cyc[nclr] = cyc;
        if (nclr == 0) sym_at_clr0 = last_sym ? nsym : -1;
        nclr++;
      end
      if (res_valid) begin
        if (nval < 4) val_cyc[nval] = cyc;
        nval++;
        check("win_ref", ref_lvl, 1000 + cyc - 1);
        check("win_pwr", map_out_pwr, -500 - (cyc - 1));
        $display("window result at cycle %0d: ref=%0d pwr=%0d", cyc, ref_lvl, map_out_pwr);
      end
      if (nclr >= 3 && cyc >= clr_cyc[2] + 3) break;
    end
    check("win_nclr", nclr, 3);
    check("win_sym_at_clr0", sym_at_clr0, 4);
    check("win_period1", clr_cyc[1] - clr_cyc[0], 64);
    check("win_period2", clr_cyc[2] - clr_cyc[1], 64);
    check("win_nval", nval, 2);
    check("win_val0_lat", val_cyc[0] - clr_cyc[1], 2);
    check("win_val1_lat", val_cyc[1] - clr_cyc[2], 2);

    // Backpressure: two captures with res_ready low, newest wins
    res_ready = 1'b0;
    nclr = 0; nlow = 0; cap_at = -1; got_first = 1'b0; exp_r = 0; exp_p = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (clr_acc) begin
        nclr++;
        cap_at = cyc + 2;
      end
      if (cyc == cap_at) begin
        exp_r = 1000 + cyc - 1;
        exp_p = -500 - (cyc - 1);
        got_first = 1'b1;
      end
      if (got_first && !res_valid) nlow++;
      if (nclr >= 2 && cyc >= cap_at + 1) break;
    end
    check("bp_nclr", nclr, 2);
    check("bp_valid_held", nlow, 0);
    check("bp_valid", res_valid, 1);
    check("bp_ref_newest", ref_lvl, exp_r);
    check("bp_pwr_newest", map_out_pwr, exp_p);
`ifdef AVG_CTRL_OVR_EN
    check("bp_overrun", overrun, 1);
`endif
    res_ready = 1'b1;
    tick();
    check("bp_accept_valid", res_valid, 0);
    check("bp_accept_ref_hold", ref_lvl, exp_r);
    $display("backpressure: result ref=%0d pwr=%0d accepted at cycle %0d", exp_r, exp_p, cyc);

    // Stop mid-window: window completes and reports, then IDLE
    repeat (20) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_busy_held", busy, 1);
    saw_clr = 1'b0; saw_val = 1'b0; val_at = -1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (clr_acc) saw_clr = 1'b1;
      if (res_valid) begin saw_val = 1'b1; val_at = cyc; end
      if (!busy) break;
    end
    check("stop_clr", saw_clr, 1);
    check("stop_valid", saw_val, 1);
    check("stop_busy", busy, 0);
    check("stop_idle_at_capture", val_at, cyc);
    nb = 0;
    repeat (20) begin
      tick();
      nb += int'(busy) + int'(load) + int'(clr_acc);
    end
    check("stop_stays_idle", nb, 0);
    $display("stop: returned to idle at cycle %0d", val_at);

    // Stop during LOAD aborts
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!load && n < 20) begin tick(); n++; end
    check("ldstop_load_up", load, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("ldstop_load", load, 0);
    check("ldstop_busy", busy, 0);
    tick();
    check("ldstop_busy_stays", busy, 0);
    $display("stop during load: aborted at cycle %0d", cyc);

    // Async reset in CAPTURE, then restart
    res_ready = 1'b0;
    load_seq("rs0");
    nclr = 0; cap_at = -1;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (clr_acc) begin nclr++; cap_at = cyc + 1; end
      if (nclr >= 3 && cyc == cap_at) break;
    end
    check("arst_pre_valid", res_valid, 1);
    check("arst_pre_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("arst_load", load, 0);
    check("arst_clr", clr_acc, 0);
    check("arst_valid", res_valid, 0);
    check("arst_ref", ref_lvl, 0);
    check("arst_pwr", map_out_pwr, 0);
    check("arst_busy", busy, 0);
`ifdef AVG_CTRL_OVR_EN
    check("arst_ovr", overrun, 0);
`endif
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    $display("async reset applied in capture, released at cycle %0d", cyc);
    load_seq("rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/avg_mag_ctrl.md
# avg_mag_ctrl

Sequencer for the average-magnitude measurement path. It starts the stimulus LFSR with a sample-aligned `load` pulse and frames fixed-length accumulation windows for `avg_mag` with `clr_acc`. At the end of each window it captures `ref_lvl`/`map_out_pwr` into a valid/ready result register. It runs on `sys_clk` beside `clk_en` and replaces the free-running `cycle` strobe as the `clr_acc` source.

## Interface
- `N_SYM_LOG2`, 7: window length = 2^N_SYM_LOG2 symbols; must equal the avg_mag accumulation window.
- `LOAD_CYC`, 4: `load` high time, in clocks.
- `CAP_DLY`, 1: clocks from `clr_acc` to result capture (1..7).
- `clk` in 1: system clock (`sys_clk`).
- `reset` in 1: asynchronous, active-high.
- `sam_clk_en` in 1: sample strobe, one clock wide.
- `sym_clk_en` in 1: symbol strobe, one clock wide, coincident with a `sam_clk_en`.
- `start` in 1: level, sampled in IDLE.
- `stop` in 1: one-clock request.
- `ref_lvl_in` in 18 signed: from avg_mag.
- `map_out_pwr_in` in 18 signed: from avg_mag.
- `load` out 1: LFSR load.
- `clr_acc` out 1: avg_mag accumulator clear/dump.
- `ref_lvl` out 18 signed: captured result.
- `map_out_pwr` out 18 signed: captured result.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts.
- `busy` out 1: state ≠ IDLE.
- `overrun` out 1: sticky; present only with `AVG_CTRL_OVR_EN`.

## Operation
- All outputs are registered. Reset value is 0 for every output; state = IDLE; counters = 0.
- IDLE: `start`=1 → LOAD_WAIT.
- LOAD_WAIT: the first `sam_clk_en` → LOAD.
- LOAD: `load`=1 for exactly LOAD_CYC clocks, then → ACCUM with `sym_cnt`=0 and `first`=1.
- ACCUM: `sym_cnt` increments on `sym_clk_en` and wraps at 2^N_SYM_LOG2 − 1. A `sym_clk_en` while `sym_cnt` is at terminal count → DUMP.
- DUMP: `clr_acc`=1 for exactly one clock, then → CAPTURE. `sym_cnt` is already 0, so counting of the next window continues without gaps.
- CAPTURE: waits CAP_DLY clocks, then latches `ref_lvl_in`/`map_out_pwr_in` into `ref_lvl`/`map_out_pwr` and sets `res_valid`. Exception: if `first`=1, nothing is latched (the window is contaminated by the load transient) and `first` is cleared. Next state is ACCUM, or IDLE if `stop_pend`. A `sym_clk_en` during DUMP/CAPTURE still counts.
- `stop`:
  - In LOAD_WAIT or LOAD: abort → IDLE next clock; `load` drops.
  - In ACCUM, DUMP or CAPTURE: set `stop_pend`; the current window completes and is reported.
  - In IDLE: ignored.
- `stop_pend` is cleared on entry to IDLE.
- Handshake:
  - `res_valid` stays high until a clock with `res_ready`=1, then clears.
  - The result registers are stable while `res_valid`=1, except on overwrite.
  - A capture in the same clock as the ready-accept leaves `res_valid`=1 with new data. This is not an overrun.
  - A capture while `res_valid`=1 and `res_ready`=0 overwrites the result (newest wins).
- Widths: no arithmetic on the data; pass-through only. `sym_cnt` is N_SYM_LOG2 bits; the load/capture counter is 3 bits min, sized by `$clog2(LOAD_CYC+1)`.

## Timing
- `start` → `load` rises 1 clock after the first `sam_clk_en` seen in LOAD_WAIT. If `sam_clk_en` coincides with the `start` cycle, it is not used.
- Last `load` clock → ACCUM on the next clock.
- Terminal `sym_clk_en` (clock t) → `clr_acc` high at t+1 → capture at t+1+CAP_DLY → `res_valid` visible at t+2+CAP_DLY.
- Result period: one per 2^N_SYM_LOG2 `sym_clk_en`. The first result comes at the end of the second window after load.
- `reset` mid-operation: immediate return to IDLE. `load`, `clr_acc`, `res_valid` and `overrun` clear asynchronously, and the result data clears.

## Configuration
- `AVG_CTRL_OVR_EN` defined:
  - `overrun` port exists.
  - Set when a capture overwrites an unaccepted result.
  - Cleared only by `reset` or the IDLE→LOAD_WAIT transition.
- Not defined: the port and its logic are absent; overwrite behaviour is unchanged.

## Test plan
- Reset/idle: assert `reset` for 2 clocks with `start`=0 → all outputs 0; `busy`=0 for 100 clocks.
- Load alignment: `sam_clk_en` every 4 clocks, `start` asserted → `load` high 4 clocks, beginning 1 clock after the next `sam_clk_en`.
- Windowing: N_SYM_LOG2=2, `sym_clk_en` every 16 clocks, `ref_lvl_in`=18'sd1000, `map_out_pwr_in`=−18'sd500, `res_ready`=1 → `clr_acc` pulses every 64 clocks. The first window yields no `res_valid`. From the second window on, `res_valid` pulses one clock with 1000 / −500 at terminal+3.
- Backpressure: `res_ready`=0 across two windows → the second result overwrites the first; `overrun`=1 (macro on); then `res_ready`=1 → `res_valid` falls next clock.
- Stop: pulse `stop` mid-window → `clr_acc` and the result still occur, then IDLE and `busy`=0. `stop` during LOAD → `load` low next clock, IDLE.
- Async reset during CAPTURE → outputs 0 immediately; restart with `start` reproduces the load timing.
